stream_avg: RTL and testbench
=============================

# stream_avg

Parametrised streaming averager: accepts a block of up to MAXSAMP unsigned samples over a valid/ready handshake and accumulates them. It then computes the truncated mean with a multi-cycle restoring divider and presents the result over an output valid/ready handshake. It generalises the fixed 8-input add/register chain plus divider used in the datapath circuits to variable-length blocks, any width and flow control.

## Interface
- DATAWIDTH, 16, sample and result width (unsigned)
- MAXSAMP, 8, maximum samples per block; block auto-terminates when reached; must be ≥1
- CNTW, $clog2(MAXSAMP+1), derived localparam; sample counter width
- ACCW, DATAWIDTH+CNTW, derived localparam; accumulator/dividend width

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present
- in_data  in  DATAWIDTH  sample value
- in_last  in  1  qualifies in_data as final sample of block
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- avg  out  DATAWIDTH  floor(sum/count)
- cnt  out  CNTW  number of samples in the averaged block

## Operation
- States: ACC, DIV, HOLD. Reset → ACC, accumulator=0, count=0, avg=0, cnt=0, out_valid=0, in_ready=1.
- ACC: in_ready=1. On in_valid&&in_ready: acc+=in_data (ACCW bits, zero-extended), count+=1.
  - Terminating sample is in_last=1 or count reaching MAXSAMP; it is accumulated, then state → DIV.
  - in_last is ignored unless in_valid.
- DIV: in_ready=0; restoring unsigned division acc/count, one quotient bit per cycle, MSB first, ACCW iterations. Divisor ≥1 always: a block cannot terminate without a sample.
- Quotient ≤ 2^DATAWIDTH−1 by construction; avg takes the low DATAWIDTH bits; remainder is discarded (truncation toward zero).
- HOLD: out_valid=1, avg/cnt stable, in_ready=0. On out_valid&&out_ready: out_valid→0, acc/count cleared, state→ACC. avg/cnt keep last value until the next result.
- No overlap between blocks: input is back-pressured during DIV and HOLD.
- Reset asserted in any state: immediate return to reset values; partial block or pending result is discarded.

## Timing
- Accept edge E0 of terminating sample → state DIV from E0.
- Divider iterates on edges E1..E_ACCW → out_valid=1 after E_ACCW.
  - Latency is exactly ACCW cycles from accept edge to out_valid (20 with defaults).
- Output handshake edge Eh → in_ready=1 immediately after Eh; zero-bubble return to ACC.
- out_ready high before out_valid has no effect.
- Earliest throughput: samples + ACCW + 1 cycles per block.

## Structure
- Package avg_pkg:
  - state enum (ACC, DIV, HOLD)
  - width helper for CNTW/ACCW
- One sub-module, div_seq, is natural:
  - parametrised (WIDTH) iterative restoring divider
  - start/busy/done interface; outputs quotient and remainder
  - stream_avg owns counter, accumulator, FSM and handshakes.

## Test plan
- Samples 1..8, no in_last, out_ready=1 → auto-terminate at 8; avg=4, cnt=8; out_valid exactly 20 cycles after 8th accept.
- Samples 10, 20, 31 with in_last on 31 → avg=20, cnt=3.
- Single sample 0x1234 with in_last → avg=0x1234, cnt=1.
- Eight samples of 0xFFFF → avg=0xFFFF, cnt=8; no accumulator overflow.
- Backpressure case:
  - Stimulus: out_ready low 10 cycles in HOLD, in_valid held high.
  - Response: out_valid stays 1, avg/cnt stable, in_ready 0, no samples consumed; first sample accepted the cycle after the out handshake.
- Reset (Rst=0) mid-DIV → all outputs at reset values, state ACC; next block 5, 7 with in_last → avg=6, cnt=2.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and width helpers for the streaming averager.
package avg_pkg;

    // Top-level control states.
    typedef enum logic [1:0] {
        StAcc  = 2'd0,
        StDiv  = 2'd1,
        StHold = 2'd2
    } state_e;

    // Bits needed to count 0..maxsamp samples.
    function automatic int unsigned cnt_width(input int unsigned maxsamp);
        return $clog2(maxsamp + 1);
    endfunction

    // Accumulator width: a full block of maximum samples cannot overflow.
    function automatic int unsigned acc_width(input int unsigned datawidth,
                                              input int unsigned maxsamp);
        return datawidth + cnt_width(maxsamp);
    endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// start_i loads the operands; WIDTH cycles later done_o pulses for one cycle.
// quotient_o/remainder_o carry the final result during the done_o cycle and
// are meant to be captured by the consumer on that same clock edge.
module div_seq #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned IterW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IterW-1:0] LastIter = IterW'(WIDTH - 1);

    // dvd_q shifts the dividend out at the top and the quotient in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q;
    logic [IterW-1:0] iter_q;
    logic             busy_q;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             fits;

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    always_comb begin
        partial = {rem_q, dvd_q[WIDTH-1]};
        diff    = partial - {1'b0, dsr_q};
        fits    = ~diff[WIDTH];
        rem_d   = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], fits};
    end

    // Operand load on start, then one iteration per cycle while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            dvd_q  <= dividend_i;
            rem_q  <= '0;
            dsr_q  <= divisor_i;
            iter_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            iter_q <= iter_q + 1'b1;
            if (iter_q == LastIter) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (iter_q == LastIter);
    assign quotient_o  = dvd_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/stream_avg.sv
// Streaming block averager: accumulates up to MAXSAMP samples, then divides
// the sum by the sample count and holds the truncated mean until taken.
module stream_avg
    import avg_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned MAXSAMP   = 8
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              in_valid,
    input  logic [DATAWIDTH-1:0]              in_data,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATAWIDTH-1:0]              avg,
    output logic [avg_pkg::cnt_width(MAXSAMP)-1:0] cnt
);

    localparam int unsigned CNTW = cnt_width(MAXSAMP);
    localparam int unsigned ACCW = acc_width(DATAWIDTH, MAXSAMP);
    localparam logic [CNTW-1:0] MaxCnt = CNTW'(MAXSAMP);

    state_e                state_q;
    logic [ACCW-1:0]       acc_q;
    logic [CNTW-1:0]       count_q;
    logic [DATAWIDTH-1:0]  avg_q;
    logic [CNTW-1:0]       cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [ACCW-1:0]       acc_sum;
    logic [CNTW-1:0]       count_inc;
    logic                  accept;
    logic                  terminate;
    logic                  div_start;

    logic                  div_busy;
    logic                  div_done;
    logic [ACCW-1:0]       div_quot;
    logic [ACCW-1:0]       div_rem;
    logic                  unused_div;

    // Next accumulator/count values and block-termination decode.
    always_comb begin
        acc_sum   = acc_q + ACCW'(in_data);
        count_inc = count_q + 1'b1;
        accept    = (state_q == StAcc) && in_valid && in_ready_q;
        terminate = in_last || (count_inc == MaxCnt);
        div_start = accept && terminate;
    end

    // The divider is fed the post-accumulation sum directly so it loads on
    // the accept edge and the result lands exactly ACCW edges later.
    div_seq #(
        .WIDTH (ACCW)
    ) u_div (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .start_i     (div_start),
        .dividend_i  (acc_sum),
        .divisor_i   (ACCW'(count_inc)),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    // Quotient high bits are zero by construction; remainder is discarded.
    assign unused_div = ^{div_busy, div_rem, div_quot[ACCW-1:DATAWIDTH]};

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        acc_q   <= acc_sum;
                        count_q <= count_inc;
                        if (terminate) begin
                            state_q    <= StDiv;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_q     <= StHold;
                        out_valid_q <= 1'b1;
                        avg_q       <= div_quot[DATAWIDTH-1:0];
                        cnt_q       <= count_q;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StAcc;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        acc_q       <= '0;
                        count_q     <= '0;
                    end
                end
                default: begin
                    state_q     <= StAcc;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign avg       = avg_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_stream_avg.sv
// Directed self-checking bench for stream_avg with default parameters.
module tb_stream_avg;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] avg;
    logic [CW-1:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    stream_avg #(
        .DATAWIDTH (16),
        .MAXSAMP   (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .avg       (avg),
        .cnt       (cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one sample; returns just after the accepting clock edge.
    task automatic send(input logic [DW-1:0] d, input logic last);
        int waits = 0;
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waits < 100) begin
            @(negedge Clk);
            waits++;
        end
        if (waits >= 100) check_eq("send_timeout", waits, 0);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count edges until out_valid rises (bounded).
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge Clk);
            #1;
            cycles++;
        end
        if (!out_valid) check_eq("result_timeout", cycles, 0);
    endtask

    // Check the held result, then complete the output handshake.
    task automatic take_result(input string tag, input logic [DW-1:0] ea, input logic [CW-1:0] ec);
        int cyc;
        wait_result(cyc);
        check_eq({tag, "_avg"}, avg, ea);
        check_eq({tag, "_cnt"}, cnt, ec);
        check_eq({tag, "_in_ready_hold"}, in_ready, 0);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_after"}, out_valid, 0);
        check_eq({tag, "_in_ready_after"}, in_ready, 1);
        check_eq({tag, "_avg_kept"}, avg, ea);
    endtask

    initial begin
        int lat;

        #2 Rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_avg", avg, 0);
        check_eq("rst_cnt", cnt, 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;

        // Samples 1..8 without in_last: auto-terminate, sum 36 / 8 = 4.
        for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
        check_eq("auto_term_in_ready", in_ready, 0);
        wait_result(lat);
        check_eq("latency", lat, 20);
        take_result("seq8", 16'd4, 4'd8);

        // 10+20+31 = 61, /3 = 20.
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd31, 1'b1);
        check_eq("last_in_ready", in_ready, 0);
        take_result("three", 16'd20, 4'd3);

        send(16'h1234, 1'b1);
        take_result("single", 16'h1234, 4'd1);

        // Full-scale block: 0x7FFF8 / 8 = 0xFFFF, needs the wide accumulator.
        for (int i = 0; i < 8; i++) send(16'hFFFF, 1'b0);
        take_result("full", 16'hFFFF, 4'd8);

        // Backpressure: result held, no sample consumed while in HOLD.
        send(16'd2, 1'b0);
        send(16'd4, 1'b1);
        wait_result(lat);
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = 16'd100;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_avg", avg, 3);
            check_eq("bp_cnt", cnt, 2);
        end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_in_ready_after", in_ready, 1);
        check_eq("bp_out_valid_after", out_valid, 0);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("bp_first_accept", in_ready, 0);
        take_result("bp_next", 16'd100, 4'd1);

        // Reset in the middle of a division discards the block.
        send(16'd9, 1'b1);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_avg", avg, 0);
        check_eq("midrst_cnt", cnt, 0);
        @(negedge Clk);
        Rst = 1'b1;
        send(16'd5, 1'b0);
        send(16'd7, 1'b1);
        take_result("post_rst", 16'd6, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
